// File: rtl/quad_decoder.sv
// -----------------------------------------------------------------------------
// quad_decoder
//
// Quadrature encoder front end. The raw a/b/z pins are brought into the clk
// domain with two-flop synchronizers, debounced by per-channel stability
// filters, and then decoded into step/direction pulses, an illegal-transition
// error pulse with a saturating error count, and an index pulse on each rising
// edge of the filtered z channel.
//
// After reset or clr the decoder spends a settle period ignoring its inputs so
// that whatever level the encoder is already sitting at is adopted silently.
//
// Parameters
//   FILTER_LEN  consecutive stable cycles before a filtered input follows (2..15)
//   ERR_BITS    width of the saturating error counter
//   INVERT      1 swaps the meaning of dir
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   asynchronous reset, active low
//   clr      in   synchronous clear: error count to 0, decoder re-armed
//   en       in   enables step/err/index pulse generation
//   a, b     in   raw encoder channels (asynchronous)
//   z        in   raw index channel (asynchronous)
//   step     out  one-cycle pulse per legal quadrature transition
//   dir      out  direction of the last legal transition (1 = forward)
//   err      out  one-cycle pulse on an illegal (both-bits) transition
//   err_cnt  out  saturating count of illegal transitions
//   index    out  one-cycle pulse on each rising edge of filtered z
// -----------------------------------------------------------------------------
module quad_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int ERR_BITS   = 8,
    parameter int INVERT     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic                a,
    input  logic                b,
    input  logic                z,
    output logic                step,
    output logic                dir,
    output logic                err,
    output logic [ERR_BITS-1:0] err_cnt,
    output logic                index
);

    // Channel order inside the packed vectors: bit 0 = a, bit 1 = b, bit 2 = z.
    localparam int NCH = 3;

    localparam logic [3:0]          FCNT_LAST   = 4'(FILTER_LEN - 1);
    localparam logic [4:0]          SETTLE_LAST = 5'(FILTER_LEN + 1);
    localparam logic                FWD_DIR     = (INVERT == 0) ? 1'b1 : 1'b0;
    localparam logic [ERR_BITS-1:0] ERR_MAX     = '1;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    logic [NCH-1:0]       raw;
    logic [NCH-1:0]       sync_s1;
    logic [NCH-1:0]       sync_s2;
    logic [NCH-1:0]       filt;
    logic [NCH-1:0]       filt_nxt;
    logic [NCH-1:0][3:0]  fcnt;
    logic [NCH-1:0][3:0]  fcnt_nxt;

    state_t               state;
    logic [4:0]           settle_cnt;
    logic [1:0]           prev_ab;
    logic                 prev_z;
    logic [1:0]           cur_ab;
    logic [1:0]           delta;

    // Position of an {a,b} pair along the forward cycle 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        logic [1:0] pos;
        case (ab)
            2'b00:   pos = 2'd0;
            2'b10:   pos = 2'd1;
            2'b11:   pos = 2'd2;
            default: pos = 2'd3;
        endcase
        return pos;
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [ERR_BITS-1:0] sat_inc(input logic [ERR_BITS-1:0] v);
        logic [ERR_BITS-1:0] r;
        if (v == ERR_MAX) begin
            r = v;
        end else begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    assign raw = {z, b, a};

    // ---- filter next-state ---------------------------------------------------
    // The counter only runs while the synchronized level disagrees with the
    // filtered level; any agreement resets it, so only an unbroken run of
    // FILTER_LEN disagreeing samples moves the filtered value.
    always_comb begin
        filt_nxt = filt;
        fcnt_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync_s2[i] != filt[i]) begin
                if (fcnt[i] == FCNT_LAST) begin
                    filt_nxt[i] = sync_s2[i];
                end else begin
                    fcnt_nxt[i] = fcnt[i] + 4'd1;
                end
            end
        end
    end

    // ---- synchronizers and filters (not touched by clr) ----------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_s1 <= '0;
            sync_s2 <= '0;
            filt    <= '0;
            fcnt    <= '0;
        end else begin
            sync_s1 <= raw;
            sync_s2 <= sync_s1;
            filt    <= filt_nxt;
            fcnt    <= fcnt_nxt;
        end
    end

    assign cur_ab = {filt[0], filt[1]};

    // Modulo-4 distance travelled since last cycle: 1 forward, 3 reverse,
    // 2 means both channels moved at once.
    assign delta  = quad_pos(cur_ab) - quad_pos(prev_ab);

    // ---- decoder FSM ---------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            prev_ab    <= '0;
            prev_z     <= 1'b0;
            step       <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            index      <= 1'b0;
        end else begin
            step  <= 1'b0;
            err   <= 1'b0;
            index <= 1'b0;

            if (clr) begin
                // clr wins over anything the decoder would report this cycle.
                state      <= SETTLE;
                settle_cnt <= '0;
                err_cnt    <= '0;
            end else begin
                case (state)
                    SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            // Take the level the filters hold after this edge,
                            // so a pin level that completes filtering right now
                            // is adopted as the baseline rather than decoded.
                            settle_cnt <= '0;
                            prev_ab    <= {filt_nxt[0], filt_nxt[1]};
                            prev_z     <= filt_nxt[2];
                            state      <= RUN;
                        end else begin
                            settle_cnt <= settle_cnt + 5'd1;
                        end
                    end

                    RUN: begin
                        // Track every cycle, even when disabled, so enabling
                        // never replays stale movement.
                        prev_ab <= cur_ab;
                        prev_z  <= filt[2];
                        if (en) begin
                            case (delta)
                                2'd1: begin
                                    step <= 1'b1;
                                    dir  <= FWD_DIR;
                                end
                                2'd3: begin
                                    step <= 1'b1;
                                    dir  <= ~FWD_DIR;
                                end
                                2'd2: begin
                                    err     <= 1'b1;
                                    err_cnt <= sat_inc(err_cnt);
                                end
                                default: begin
                                end
                            endcase
                            index <= filt[2] & ~prev_z;
                        end
                    end

                    default: begin
                        state <= SETTLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// -----------------------------------------------------------------------------
// tb_quad_decoder
//
// Directed stimulus for quad_decoder with a behavioural reference model.
// The model describes the filtered channels as "follow the pin once its last
// FILTER_LEN synchronized samples all disagree with the current level", tracks
// time since reset/clr as a plain edge count, and decodes movement through
// the Gray-code position of {a,b}. A compare process checks every output on
// every cycle; the stimulus adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_quad_decoder;

    localparam int FL  = 4;
    localparam int EB  = 8;
    localparam int INV = 0;
    localparam int CNT_MAX = (1 << EB) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clr = 1'b0;
    logic          en  = 1'b0;
    logic          a   = 1'b0;
    logic          b   = 1'b0;
    logic          z   = 1'b0;
    logic          step;
    logic          dir;
    logic          err;
    logic [EB-1:0] err_cnt;
    logic          index;

    quad_decoder #(
        .FILTER_LEN(FL),
        .ERR_BITS  (EB),
        .INVERT    (INV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .a      (a),
        .b      (b),
        .z      (z),
        .step   (step),
        .dir    (dir),
        .err    (err),
        .err_cnt(err_cnt),
        .index  (index)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_step = 0;
    int n_err  = 0;
    int n_idx  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Gray position of {a,b} along the forward cycle 00,10,11,01.
    function automatic int qpos(input bit av, input bit bv);
        return 2 * int'(bv) + int'(av ^ bv);
    endfunction

    // ---- reference model -----------------------------------------------------
    bit hist [3][FL+1];   // hist[ch][i] = pin level sampled i+1 edges ago
    bit fcur [3];         // filtered level after the previous edge
    bit fprv [3];         // filtered level after the edge before that
    bit nf   [3];
    bit raw  [3];
    int s_cnt;            // edges since reset / clr
    int m_cnt;
    bit m_dir, m_step, m_err, m_idx;
    bit allflip, s_clr, s_en, s_rst;
    int d;

    initial begin
        for (int c = 0; c < 3; c++) begin
            fcur[c] = 1'b0;
            fprv[c] = 1'b0;
            for (int i = 0; i <= FL; i++) hist[c][i] = 1'b0;
        end
        s_cnt = 0; m_cnt = 0; m_dir = 0; m_step = 0; m_err = 0; m_idx = 0;
    end

    always @(posedge clk) begin
        raw[0] = a; raw[1] = b; raw[2] = z;
        s_clr = clr; s_en = en; s_rst = rst;
        if (!s_rst) begin
            for (int c = 0; c < 3; c++) begin
                fcur[c] = 1'b0;
                fprv[c] = 1'b0;
                for (int i = 0; i <= FL; i++) hist[c][i] = 1'b0;
            end
            s_cnt = 0; m_cnt = 0; m_dir = 0; m_step = 0; m_err = 0; m_idx = 0;
        end else begin
            m_step = 0; m_err = 0; m_idx = 0;
            if (s_clr) begin
                s_cnt = 0;
                m_cnt = 0;
            end else begin
                if (s_cnt < 1000000) s_cnt++;
                // Filtered changes up to the end of the settle period are
                // absorbed; decoding of later changes starts here.
                if (s_cnt >= FL + 4 && s_en) begin
                    d = (qpos(fcur[0], fcur[1]) - qpos(fprv[0], fprv[1]) + 4) % 4;
                    if (d == 1) begin
                        m_step = 1; m_dir = (INV == 0);
                    end else if (d == 3) begin
                        m_step = 1; m_dir = (INV != 0);
                    end else if (d == 2) begin
                        m_err = 1;
                        if (m_cnt < CNT_MAX) m_cnt++;
                    end
                    m_idx = fcur[2] && !fprv[2];
                end
            end
            for (int c = 0; c < 3; c++) begin
                allflip = 1'b1;
                for (int i = 1; i <= FL; i++) if (hist[c][i] == fcur[c]) allflip = 1'b0;
                nf[c] = allflip ? !fcur[c] : fcur[c];
                fprv[c] = fcur[c];
                fcur[c] = nf[c];
                for (int i = FL; i >= 1; i--) hist[c][i] = hist[c][i-1];
                hist[c][0] = raw[c];
            end
        end
        #1;
        chk("model_step",    step,    m_step);
        chk("model_err",     err,     m_err);
        chk("model_index",   index,   m_idx);
        chk("model_dir",     dir,     m_dir);
        chk("model_err_cnt", err_cnt, m_cnt);
        if (step  === 1'b1) n_step++;
        if (err   === 1'b1) n_err++;
        if (index === 1'b1) n_idx++;
    end

    // ---- stimulus ------------------------------------------------------------
    int p;
    int s0, e0, i0;

    task automatic set_pos(input int pos);
        b = (pos >= 2);
        a = ((pos % 2) == 1) ^ (pos >= 2);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with the encoder already parked at 11.
        a = 1; b = 1; z = 0; en = 1; clr = 0; rst = 0;
        p = 2;
        cyc(3);
        chk("reset_step",    step,    0);
        chk("reset_err",     err,     0);
        chk("reset_index",   index,   0);
        chk("reset_dir",     dir,     0);
        chk("reset_err_cnt", err_cnt, 0);

        rst = 1;
        s0 = n_step; e0 = n_err;
        cyc(20);
        chk("settle_no_err",  n_err - e0,  0);
        chk("settle_no_step", n_step - s0, 0);
        chk("settle_err_cnt", err_cnt,     0);

        // 8 forward transitions, first one timed edge by edge.
        s0 = n_step;
        for (int t = 0; t < 8; t++) begin
            p = (p + 1) % 4;
            set_pos(p);
            if (t == 0) begin
                repeat (6) @(posedge clk);
                #1 chk("fwd_lat_early", step, 0);
                @(posedge clk);
                #1 chk("fwd_lat_step", step, 1);
                chk("fwd_lat_dir", dir, 1);
                cyc(14);
            end else begin
                cyc(20);
            end
        end
        chk("fwd_steps", n_step - s0, 8);

        // 3-cycle glitch on a.
        s0 = n_step; e0 = n_err;
        a = ~a;
        cyc(3);
        a = ~a;
        cyc(20);
        chk("glitch_no_step", n_step - s0, 0);
        chk("glitch_no_err",  n_err - e0,  0);

        // 300 simultaneous toggles of a and b.
        e0 = n_err;
        for (int t = 0; t < 300; t++) begin
            p = (p + 2) % 4;
            set_pos(p);
            cyc(7);
        end
        chk("err_pulses", n_err - e0, 300);
        chk("err_sat",    err_cnt,    CNT_MAX);

        // clr, with a both-bits change landing during the following settle.
        clr = 1;
        p = (p + 2) % 4;
        set_pos(p);
        @(posedge clk);
        #1 chk("clr_zero", err_cnt, 0);
        @(negedge clk);
        clr = 0;
        e0 = n_err;
        cyc(20);
        chk("clr_settle_no_err", n_err - e0, 0);
        chk("clr_settle_cnt",    err_cnt,    0);

        // clr coinciding with an illegal transition.
        for (int t = 0; t < 2; t++) begin
            p = (p + 2) % 4;
            set_pos(p);
            cyc(10);
        end
        chk("two_errs", err_cnt, 2);
        p = (p + 2) % 4;
        set_pos(p);
        cyc(6);
        clr = 1;
        @(posedge clk);
        #1 chk("clr_prio_err", err, 0);
        chk("clr_prio_cnt", err_cnt, 0);
        @(negedge clk);
        clr = 0;
        cyc(20);

        // Reverse motion and index activity while disabled.
        en = 0;
        s0 = n_step; i0 = n_idx;
        for (int t = 0; t < 5; t++) begin
            p = (p + 3) % 4;
            set_pos(p);
            cyc(20);
        end
        z = 1; cyc(10); z = 0; cyc(10);
        chk("dis_no_step",  n_step - s0, 0);
        chk("dis_no_index", n_idx - i0,  0);
        en = 1;
        cyc(15);
        chk("no_burst", n_step - s0, 0);
        p = (p + 3) % 4;
        set_pos(p);
        repeat (7) @(posedge clk);
        #1 chk("rev_step", step, 1);
        chk("rev_dir", dir, 0);
        cyc(20);
        i0 = n_idx;
        z = 1; cyc(10); z = 0; cyc(10);
        chk("index_one", n_idx - i0, 1);

        // Build up dir=1 and err_cnt=17, then reset asynchronously.
        p = (p + 1) % 4;
        set_pos(p);
        cyc(20);
        chk("fwd_dir_again", dir, 1);
        for (int t = 0; t < 17; t++) begin
            p = (p + 2) % 4;
            set_pos(p);
            cyc(10);
        end
        chk("err_cnt_17", err_cnt, 17);
        @(negedge clk);
        #2 rst = 0;
        #1;
        chk("async_step",    step,    0);
        chk("async_err",     err,     0);
        chk("async_index",   index,   0);
        chk("async_dir",     dir,     0);
        chk("async_err_cnt", err_cnt, 0);
        cyc(3);
        rst = 1;
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 4: consecutive stable cycles required before a filtered input changes; legal range 2..15.
REQ-002 Parameter ERR_BITS, default 8: width of the saturating error counter.
REQ-003 Parameter INVERT, default 0: when 1, the meaning of dir is swapped.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 clr  input  1  synchronous clear: error counter cleared, decoder re-armed.
REQ-007 en  input  1  enables step/err/index pulse generation.
REQ-008 a, b  input  1 each  raw encoder channels, asynchronous to clk.
REQ-009 z  input  1  raw index channel, asynchronous to clk.
REQ-010 step  output  1  one-cycle pulse per legal quadrature transition; drives a downstream counter's en.
REQ-011 dir  output  1  direction of the last legal transition; 1 = forward (INVERT=0).
REQ-012 err  output  1  one-cycle pulse on an illegal transition (both channels changed together).
REQ-013 err_cnt  output  ERR_BITS  saturating count of illegal transitions.
REQ-014 index  output  1  one-cycle pulse on each rising edge of filtered z.

Function
REQ-015 Each of a, b, z SHALL pass through a 2-flop synchronizer (s1, s2).
REQ-016 Each channel SHALL have a filter counter: reset to 0 while s2 equals the filtered value; incremented while they differ; when the counter equals FILTER_LEN-1 and they still differ, the filtered value takes s2 and the counter returns to 0.
REQ-017 Latency: a pin level first sampled by s1 at edge k SHALL appear on the filtered value after edge k+1+FILTER_LEN; the resulting step/err/index pulse SHALL be high after edge k+2+FILTER_LEN.
REQ-018 A glitch shorter than FILTER_LEN cycles at s2 SHALL produce no filtered change and no pulse.
REQ-019 The FSM SHALL have states SETTLE and RUN; reset and clr SHALL enter SETTLE.
REQ-020 SETTLE SHALL last FILTER_LEN+2 cycles, counted by a settle counter; step, err and index SHALL be 0 throughout.
REQ-021 On leaving SETTLE, prev SHALL be loaded from the current filtered {a,b} and the FSM SHALL enter RUN.
REQ-022 In RUN, prev SHALL be updated every cycle to the filtered {a,b}, regardless of en.
REQ-023 In RUN with en=1, forward sequence {a,b} 00->10->11->01->00 SHALL give step=1 and dir=1 (dir=0 if INVERT=1).
REQ-024 In RUN with en=1, the reverse sequence SHALL give step=1 and dir=0 (dir=1 if INVERT=1).
REQ-025 In RUN with en=1, a change of both bits in one cycle SHALL give err=1, step=0, dir unchanged, and err_cnt+1 saturating at 2^ERR_BITS-1.
REQ-026 With en=0, step, err and index SHALL be 0, err_cnt and dir SHALL hold, and prev SHALL keep tracking, so re-enabling produces no burst.
REQ-027 clr SHALL zero err_cnt at the next edge and SHALL take priority over a simultaneous illegal transition; synchronizers and filters SHALL be unaffected by clr.
REQ-028 The index pulse SHALL require RUN and en=1; it is independent of step.

Reset
REQ-029 While rst=0, all synchronizer flops, filtered values, filter counters, settle counter, prev, step, dir, err, err_cnt and index SHALL be 0, and the FSM SHALL be in SETTLE.
REQ-030 Reset asserted mid-operation SHALL take effect immediately, without waiting for clk.
REQ-031 After reset release, the block SHALL behave as on entry to SETTLE, so pins already at 11 produce no err.

Verification
REQ-032 Release reset with a=b=1 held -> no err or step pulse; RUN is entered after FILTER_LEN+2 cycles; err_cnt=0.
REQ-033 With FILTER_LEN=4, en=1, drive 8 forward transitions each 20 cycles apart -> 8 step pulses with dir=1, the first high 6 edges after s1 samples the change.
REQ-034 Drive a 3-cycle pulse on a (FILTER_LEN=4) -> no step, no err.
REQ-035 Toggle a and b together 300 times (ERR_BITS=8) -> 300 err pulses; err_cnt saturates at 255; then clr -> err_cnt=0 and no pulse during the following SETTLE.
REQ-036 Drive 5 reverse transitions with en=0, then raise en -> no pulses while en=0, no burst on raising en; the next reverse transition gives step=1 with dir=0.
REQ-037 Assert rst mid-sequence with err_cnt=17 -> all outputs 0 immediately, asynchronously.
